// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor that sits in front of the PC register. Each cycle
// the fetch PC is looked up in a direct-mapped branch target buffer (BTB).
// Every entry holds a valid bit, a tag, a target and a 2-bit saturating
// counter. The lookup produces the predicted next PC. When EX resolves a
// branch, the table is trained, mispredictions are flagged together with the
// corrected PC, and two performance counters advance.
//
// Parameters
//   ENTRIES  number of BTB entries (power of two, >= 2)
//   INDEX_W  log2(ENTRIES); index = pc[INDEX_W+1:2], tag = pc[31:INDEX_W+2]
//
// Ports
//   clk_i              clock
//   rst_i              asynchronous, active-high reset
//   fetch_pc_i         current PC register output
//   next_pc_o          predicted next PC (PC register input)
//   pred_taken_o       prediction for fetch_pc_i
//   pred_target_o      BTB target for fetch_pc_i, 0 on miss
//   mem_stall_i        pipeline frozen; blocks table and counter updates
//   upd_valid_i        branch in EX resolved this cycle
//   upd_pc_i           PC of the resolved branch
//   upd_taken_i        actual outcome
//   upd_target_i       actual target
//   upd_pred_taken_i   prediction made at fetch
//   upd_pred_target_i  target predicted at fetch
//   mispredict_o       flush IF/ID and redirect
//   redirect_pc_o      corrected PC
//   branch_cnt_o       resolved branches counted
//   mispred_cnt_o      mispredictions counted
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fetch_pc_i,
  output logic [31:0] next_pc_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        mem_stall_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_pred_taken_i,
  input  logic [31:0] upd_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int TAG_W = 30 - INDEX_W;

  // 2-bit counter encoding: strongly/weakly not-taken, weakly/strongly taken.
  typedef enum logic [1:0] {
    CTR_SN = 2'b00,
    CTR_WN = 2'b01,
    CTR_WT = 2'b10,
    CTR_ST = 2'b11
  } ctr_e;

  // Control state (reset) kept in packed vectors; data payload (not reset)
  // kept in plain arrays.
  logic [ENTRIES-1:0]       valid_q;
  logic [ENTRIES-1:0][1:0]  ctr_q;
  logic [TAG_W-1:0]         tag_q    [ENTRIES];
  logic [31:0]              target_q [ENTRIES];

  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [INDEX_W-1:0] fetch_idx;
  logic [TAG_W-1:0]   fetch_tag;
  logic               fetch_hit;

  assign fetch_idx = fetch_pc_i[INDEX_W+1:2];
  assign fetch_tag = fetch_pc_i[31:INDEX_W+2];
  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

  assign pred_taken_o  = fetch_hit && ctr_q[fetch_idx][1];
  assign pred_target_o = fetch_hit ? target_q[fetch_idx] : 32'd0;
  // Sequential fetch wraps naturally mod 2^32.
  assign next_pc_o     = pred_taken_o ? target_q[fetch_idx] : fetch_pc_i + 32'd4;

  // ---------------------------------------------------------------------------
  // Resolve
  // ---------------------------------------------------------------------------
  assign mispredict_o  = upd_valid_i &&
                         ((upd_taken_i != upd_pred_taken_i) ||
                          (upd_taken_i && (upd_target_i != upd_pred_target_i)));
  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 32'd4;

  // ---------------------------------------------------------------------------
  // Update
  // ---------------------------------------------------------------------------
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_hit;
  logic               upd_en;

  assign upd_idx = upd_pc_i[INDEX_W+1:2];
  assign upd_tag = upd_pc_i[31:INDEX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  // A stalled EX branch is re-presented each cycle; only the unstalled cycle
  // trains the table and counts.
  assign upd_en  = upd_valid_i && !mem_stall_i;

  // Word-alignment bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc_i[1:0], upd_pc_i[1:0]};

  // NOTE: only valid and ctr are reset; tag and target are meaningless while
  // the entry is invalid, so they live in a reset-free block and map onto
  // plain storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q       <= '0;
      ctr_q         <= {ENTRIES{CTR_WN}};
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (upd_en) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict_o) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
      if (upd_hit) begin
        if (upd_taken_i) begin
          if (ctr_q[upd_idx] != CTR_ST) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
        end else begin
          if (ctr_q[upd_idx] != CTR_SN) ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        // Allocate or evict the aliasing entry; a not-taken miss never evicts.
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && upd_en && upd_taken_i) begin
      target_q[upd_idx] <= upd_target_i;
      if (!upd_hit) begin
        tag_q[upd_idx] <= upd_tag;
      end
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed bench for branch_predictor (ENTRIES=16). Inputs change 1 time unit
// after a rising edge; outputs are sampled 1 time unit later, well away from
// the next edge. Expected values are hand-derived constants plus a running
// tally of expected branch and misprediction counts.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] fetch_pc_i;
  logic [31:0] next_pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        mem_stall_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_mp = 0;

  branch_predictor #(.ENTRIES(16), .INDEX_W(4)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .fetch_pc_i        (fetch_pc_i),
    .next_pc_o         (next_pc_o),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .mem_stall_i       (mem_stall_i),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .mispredict_o      (mispredict_o),
    .redirect_pc_o     (redirect_pc_o),
    .branch_cnt_o      (branch_cnt_o),
    .mispred_cnt_o     (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input logic exp_pt,
                       input logic [31:0] exp_tgt, input logic [31:0] exp_next);
    fetch_pc_i = pc;
    #1;
    check({tag, ".pred_taken"},  {31'd0, pred_taken_o}, {31'd0, exp_pt});
    check({tag, ".pred_target"}, pred_target_o, exp_tgt);
    check({tag, ".next_pc"},     next_pc_o, exp_next);
  endtask

  task automatic check_cnts(input string tag);
    check({tag, ".branch_cnt"},  branch_cnt_o, exp_br);
    check({tag, ".mispred_cnt"}, mispred_cnt_o, exp_mp);
  endtask

  // One unstalled resolved branch: checks the combinational resolve outputs,
  // lets the update land at the next edge, then checks the counters.
  task automatic upd(input string tag, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                     input logic exp_mis);
    upd_pc_i          = pc;
    upd_taken_i       = tk;
    upd_target_i      = tgt;
    upd_pred_taken_i  = ptk;
    upd_pred_target_i = ptgt;
    upd_valid_i       = 1'b1;
    #1;
    check({tag, ".mispredict"}, {31'd0, mispredict_o}, {31'd0, exp_mis});
    check({tag, ".redirect"},   redirect_pc_o, tk ? tgt : pc + 32'd4);
    @(posedge clk_i);
    #1;
    upd_valid_i = 1'b0;
    exp_br = exp_br + 32'd1;
    if (exp_mis) exp_mp = exp_mp + 32'd1;
    check_cnts(tag);
  endtask

  initial begin
    rst_i             = 1'b1;
    mem_stall_i       = 1'b0;
    upd_valid_i       = 1'b0;
    upd_pc_i          = '0;
    upd_taken_i       = 1'b0;
    upd_target_i      = '0;
    upd_pred_taken_i  = 1'b0;
    upd_pred_target_i = '0;
    fetch_pc_i        = 32'h40;

    // Reset state
    fetch("rst", 32'h40, 1'b0, 32'h0, 32'h44);
    check_cnts("rst");
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    fetch("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);

    // First taken branch allocates with WT
    upd("alloc", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    fetch("alloc_hit", 32'h40, 1'b1, 32'h100, 32'h100);

    // Counter walk down: 10 -> 01 -> 00, then saturate at 00
    upd("dn1", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    upd("dn2", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    fetch("at_sn", 32'h40, 1'b0, 32'h100, 32'h44);
    upd("dn3", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Walk up: 00 -> 01 -> 10 -> 11, then saturate at 11
    upd("up1", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    fetch("at_wn", 32'h40, 1'b0, 32'h100, 32'h44);
    upd("up2", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    fetch("at_wt", 32'h40, 1'b1, 32'h100, 32'h100);
    upd("up3", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
    upd("up4", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
    // One not-taken from a saturated 11 still predicts taken (11 -> 10)
    upd("sat_dn", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    fetch("after_sat", 32'h40, 1'b1, 32'h100, 32'h100);

    // Aliasing: 0x80 shares index 0 with 0x40
    upd("alias", 32'h80, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
    fetch("alias_40", 32'h40, 1'b0, 32'h0, 32'h44);
    fetch("alias_80", 32'h80, 1'b1, 32'h200, 32'h200);
    // A not-taken miss never evicts
    upd("nt_miss", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    fetch("no_evict", 32'h80, 1'b1, 32'h200, 32'h200);

    // Stalled update: held 3 cycles, counted and trained exactly once
    mem_stall_i       = 1'b1;
    upd_pc_i          = 32'h44;
    upd_taken_i       = 1'b1;
    upd_target_i      = 32'h300;
    upd_pred_taken_i  = 1'b0;
    upd_pred_target_i = 32'h0;
    upd_valid_i       = 1'b1;
    fetch_pc_i        = 32'h44;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall.mispredict", {31'd0, mispredict_o}, 32'd1);
      check("stall.pred_taken", {31'd0, pred_taken_o}, 32'd0);
      check_cnts("stall");
      @(posedge clk_i);
      #1;
    end
    check("stall.still_untrained", {31'd0, pred_taken_o}, 32'd0);
    mem_stall_i = 1'b0;
    #1;
    check("unstall.mispredict", {31'd0, mispredict_o}, 32'd1);
    @(posedge clk_i);
    #1;
    upd_valid_i = 1'b0;
    exp_br = exp_br + 32'd1;
    exp_mp = exp_mp + 32'd1;
    check_cnts("unstall");
    fetch("unstall_hit", 32'h44, 1'b1, 32'h300, 32'h300);

    // Read-before-write on the same index: bring 0x40 to WN, then train taken
    upd("rbw_alloc", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    upd("rbw_wn", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    fetch_pc_i        = 32'h40;
    upd_pc_i          = 32'h40;
    upd_taken_i       = 1'b1;
    upd_target_i      = 32'h100;
    upd_pred_taken_i  = 1'b0;
    upd_pred_target_i = 32'h0;
    upd_valid_i       = 1'b1;
    #1;
    check("rbw.same_cycle", {31'd0, pred_taken_o}, 32'd0);
    check("rbw.same_next",  next_pc_o, 32'h44);
    @(posedge clk_i);
    #1;
    upd_valid_i = 1'b0;
    exp_br = exp_br + 32'd1;
    exp_mp = exp_mp + 32'd1;
    check("rbw.next_cycle", {31'd0, pred_taken_o}, 32'd1);
    check_cnts("rbw");

    // Reset during a pending update: reset wins
    upd_pc_i    = 32'h48;
    upd_taken_i = 1'b1;
    upd_target_i = 32'h400;
    upd_valid_i = 1'b1;
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    upd_valid_i = 1'b0;
    exp_br = 32'd0;
    exp_mp = 32'd0;
    check_cnts("rst2");
    fetch("rst2_40", 32'h40, 1'b0, 32'h0, 32'h44);
    fetch("rst2_44", 32'h44, 1'b0, 32'h0, 32'h48);
    fetch("rst2_48", 32'h48, 1'b0, 32'h0, 32'h4C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
